// File: rtl/nes_memctl.sv
// NES CPU bus controller: decodes work RAM, PPU registers and PRG ROM, and runs OAM DMA ($4014 -> PPU reg 4).
// Optional macro NES_DMA_ALIGN_EN adds a cycle-parity flop so odd-cycle DMA starts get one extra wait cycle.
module nes_memctl #(
   parameter int PRG_AW = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [15:0]       cpu_address,
   input  logic [7:0]        cpu_out,
   input  logic              cpu_rd,
   input  logic              cpu_we,
   output logic [7:0]        cpu_data,
   output logic              cpu_halt,
   output logic [10:0]       ram_address,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata,
   output logic [PRG_AW-1:0] rom_address,
   input  logic [7:0]        rom_rdata,
   output logic [2:0]        ppu_reg,
   output logic [7:0]        ppu_wdata,
   output logic              ppu_we,
   output logic              ppu_rd,
   input  logic [7:0]        ppu_rdata,
   output logic [1:0]        dbg_state
);

   // Handshake: cpu_rd/cpu_we are single-cycle requests with no ready; they are accepted only while
   // the FSM is idle (cpu_halt low) and silently dropped otherwise. Read data appears one cycle later.
   typedef enum logic [1:0] {IDLE = 2'd0, DMA_WAIT = 2'd1, DMA_READ = 2'd2, DMA_WRITE = 2'd3} state_t;
   typedef enum logic [1:0] {SRC_OPEN = 2'd0, SRC_RAM = 2'd1, SRC_PPU = 2'd2, SRC_ROM = 2'd3} src_t;

   function automatic src_t decode(input logic [15:0] a);
      src_t s;
      if (a[15])                  s = SRC_ROM;
      else if (a[14:13] == 2'b00) s = SRC_RAM;
      else if (a[14:13] == 2'b01) s = SRC_PPU;
      else                        s = SRC_OPEN;
      return s;
   endfunction

   state_t      r_state;
   src_t        r_src;
   logic        r_cpu_rd;
   logic        r_halt;
   logic [7:0]  r_page;
   logic [7:0]  r_index;
   logic [7:0]  r_hold;

   logic        w_cpu_ok;
   logic        w_dma_rd;
   logic        w_dma_wr;
   logic        w_dma_trig;
   logic [15:0] w_addr;
   src_t        w_src;
   logic [7:0]  w_src_data;
   logic [7:0]  w_cpu_data;

   assign w_cpu_ok   = (r_state == IDLE) && !reset;
   assign w_dma_rd   = (r_state == DMA_READ) && !reset;
   assign w_dma_wr   = (r_state == DMA_WRITE) && !reset;
   assign w_dma_trig = w_cpu_ok && cpu_we && (cpu_address == 16'h4014);
   assign w_addr     = (r_state == DMA_READ) ? {r_page, r_index} : cpu_address;
   assign w_src      = decode(w_addr);

   // Data of the source read last cycle; open bus falls back to the last value the CPU saw.
   always_comb begin
      w_src_data = r_hold;
      case (r_src)
         SRC_RAM: w_src_data = ram_rdata;
         SRC_PPU: w_src_data = ppu_rdata;
         SRC_ROM: w_src_data = rom_rdata;
         default: w_src_data = r_hold;
      endcase
   end

   assign w_cpu_data  = r_cpu_rd ? w_src_data : r_hold;
   assign cpu_data    = w_cpu_data;
   assign cpu_halt    = r_halt;
   assign dbg_state   = r_state;

   assign ram_address = w_addr[10:0];
   assign ram_wdata   = cpu_out;
   assign ram_we      = w_cpu_ok && cpu_we && (w_src == SRC_RAM);
   assign rom_address = w_addr[PRG_AW-1:0];

   assign ppu_reg     = w_dma_wr ? 3'd4 : w_addr[2:0];
   assign ppu_wdata   = w_dma_wr ? w_src_data : cpu_out;
   assign ppu_we      = w_dma_wr || (w_cpu_ok && cpu_we && (w_src == SRC_PPU));
   assign ppu_rd      = ((w_cpu_ok && cpu_rd) || w_dma_rd) && (w_src == SRC_PPU);

`ifdef NES_DMA_ALIGN_EN
   logic r_parity;

   always_ff @(posedge clock) begin
      if (reset) r_parity <= 1'b0;
      else       r_parity <= ~r_parity;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_src    <= SRC_OPEN;
         r_cpu_rd <= 1'b0;
         r_halt   <= 1'b0;
         r_page   <= 8'h00;
         r_index  <= 8'h00;
         r_hold   <= 8'h00;
      end else begin
         r_hold   <= w_cpu_data;
         r_src    <= w_src;
         r_cpu_rd <= w_cpu_ok && cpu_rd;
         case (r_state)
            IDLE: begin
               if (w_dma_trig) begin
                  r_page  <= cpu_out;
                  r_index <= 8'h00;
                  r_halt  <= 1'b1;
                  r_state <= DMA_WAIT;
               end
            end
            DMA_WAIT: begin
`ifdef NES_DMA_ALIGN_EN
               if (!r_parity) r_state <= DMA_READ;
`else
               r_state <= DMA_READ;
`endif
            end
            DMA_READ: r_state <= DMA_WRITE;
            DMA_WRITE: begin
               // The index never wraps into page+1: byte 255 ends the transfer.
               if (r_index == 8'hFF) begin
                  r_halt  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_index <= r_index + 8'd1;
                  r_state <= DMA_READ;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nes_memctl.sv
// Directed-plus-random bench for nes_memctl: RAM/ROM/PPU device models, a spec-level read model and DMA log checks.
module tb_nes_memctl;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] cpu_address;
   logic [7:0]  cpu_out;
   logic        cpu_rd;
   logic        cpu_we;
   logic [7:0]  cpu_data;
   logic        cpu_halt;
   logic [10:0] ram_address;
   logic [7:0]  ram_wdata;
   logic        ram_we;
   logic [7:0]  ram_rdata;
   logic [14:0] rom_address;
   logic [7:0]  rom_rdata;
   logic [2:0]  ppu_reg;
   logic [7:0]  ppu_wdata;
   logic        ppu_we;
   logic        ppu_rd;
   logic [7:0]  ppu_rdata;
   logic [1:0]  dbg_state;

   always #5 clock = ~clock;

   nes_memctl #(.PRG_AW(15)) dut (
      .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
      .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_data(cpu_data), .cpu_halt(cpu_halt),
      .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .rom_address(rom_address), .rom_rdata(rom_rdata),
      .ppu_reg(ppu_reg), .ppu_wdata(ppu_wdata), .ppu_we(ppu_we), .ppu_rd(ppu_rd),
      .ppu_rdata(ppu_rdata), .dbg_state(dbg_state)
   );

   // Device models: synchronous-read RAM and ROM, PPU answers 0xD0|reg one cycle after ppu_rd.
   logic [7:0] dev_ram   [0:2047];
   logic [7:0] rom_img   [0:32767];
   logic [7:0] model_ram [0:2047];

   always @(posedge clock) begin
      if (ram_we) dev_ram[ram_address] <= ram_wdata;
      ram_rdata <= dev_ram[ram_address];
      rom_rdata <= rom_img[rom_address];
      if (ppu_rd) ppu_rdata <= 8'hD0 | {5'd0, ppu_reg};
   end

   int cyc;
   always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

   logic [10:0] wr_q[$];
   logic [10:0] exp_q[$];
   int ppu_rd_cnt;
   int halt_cnt;
   always @(negedge clock) begin
      if (ppu_we)   wr_q.push_back({ppu_reg, ppu_wdata});
      if (ppu_rd)   ppu_rd_cnt++;
      if (cpu_halt) halt_cnt++;
   end

   int         n_err;
   int         n_chk;
   logic [7:0] exp_cpu_data;
   logic       cap_ram_we, cap_ppu_we, cap_ppu_rd;
   logic [10:0] cap_ram_address;
   logic [7:0] cap_ram_wdata, cap_ppu_wdata;
   logic [2:0] cap_ppu_reg;
   int         hb, wb, rb;
   logic       wpar;
   logic [15:0] addr_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_read(input logic [15:0] a);
      if (a < 16'h2000)  return model_ram[a[10:0]];
      if (a < 16'h4000)  return 8'hD0 | {5'd0, a[2:0]};
      if (a >= 16'h8000) return rom_img[a[14:0]];
      return exp_cpu_data;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_address = a;
      cpu_out     = d;
      cpu_we      = 1'b1;
      #1;
      cap_ram_we = ram_we;   cap_ram_address = ram_address; cap_ram_wdata = ram_wdata;
      cap_ppu_we = ppu_we;   cap_ppu_reg     = ppu_reg;     cap_ppu_wdata = ppu_wdata;
      step();
      cpu_we = 1'b0;
      if (a < 16'h2000) model_ram[a[10:0]] = d;
   endtask

   task automatic cpu_read(input string tag, input logic [15:0] a);
      cpu_address = a;
      cpu_rd      = 1'b1;
      #1;
      cap_ppu_rd = ppu_rd;
      step();
      cpu_rd = 1'b0;
      exp_cpu_data = ref_read(a);
      chk(tag, cpu_data, exp_cpu_data);
   endtask

   task automatic dma_start(input logic [7:0] page);
      hb = halt_cnt;
      wb = wr_q.size();
      rb = ppu_rd_cnt;
      cpu_write(16'h4014, page);
      wpar = cyc[0];
      chk("halt_rise", cpu_halt, 1'b1);
   endtask

   task automatic dma_wait(input bit stray);
      for (int i = 0; i < 1200 && cpu_halt; i++) begin
         if (stray && i == 10) begin
            cpu_address = 16'h4014; cpu_out = 8'h05; cpu_we = 1'b1;
            #1 chk("stray_4014_ram_we", ram_we, 1'b0);
            step();
            cpu_address = 16'h0000; cpu_out = 8'hEE;
            #1 chk("stray_0000_ram_we", ram_we, 1'b0);
            step();
            cpu_we = 1'b0; cpu_address = 16'h2002; cpu_rd = 1'b1;
            #1 chk("stray_ppu_rd", ppu_rd, 1'b0);
            step();
            cpu_rd = 1'b0;
         end else begin
            step();
         end
      end
      chk("dma_end", cpu_halt, 1'b0);
   endtask

   task automatic dma_check(input logic [7:0] page, input int n);
      logic [10:0] got;
      for (int i = 0; i < n; i++) exp_q.push_back({3'd4, ref_read({page, i[7:0]})});
      for (int i = 0; i < n; i++) begin
         got = (wb + i < wr_q.size()) ? wr_q[wb + i] : 11'h7FF;
         chk($sformatf("dma_p%02h_i%0d", page, i), got, exp_q.pop_front());
      end
   endtask

   function automatic int exp_halt();
`ifdef NES_DMA_ALIGN_EN
      return 513 + int'(wpar);
`else
      return 513;
`endif
   endfunction

   initial begin
      logic [15:0] a;
      logic [7:0]  d;
      n_err = 0; n_chk = 0; exp_cpu_data = 8'h00;
      reset = 1'b1; cpu_address = 16'h0000; cpu_out = 8'h00; cpu_rd = 1'b0; cpu_we = 1'b0;
      for (int i = 0; i < 32768; i++) rom_img[i] = 8'($urandom);
      for (int i = 0; i < 2048; i++) model_ram[i] = 8'h00;

      // Reset state
      step(); step(); step();
      chk("rst_cpu_data", cpu_data, 8'h00);
      chk("rst_halt", cpu_halt, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ppu_we", ppu_we, 1'b0);
      chk("rst_ppu_rd", ppu_rd, 1'b0);
      reset = 1'b0;
      step();

      // RAM write and mirrored reads
      cpu_write(16'h0001, 8'h5A);
      chk("wr_ram_we", cap_ram_we, 1'b1);
      chk("wr_ram_addr", cap_ram_address, 11'h001);
      chk("wr_ram_wdata", cap_ram_wdata, 8'h5A);
      cpu_read("rd_0801", 16'h0801);
      cpu_read("rd_1001", 16'h1001);
      cpu_read("rd_1801", 16'h1801);

      for (int k = 0; k < 16; k++) begin
         a = 16'($urandom_range(0, 16'h1FFF));
         d = 8'($urandom);
         cpu_write(a, d);
         addr_q.push_back(a);
      end
      while (addr_q.size() > 0) begin
         a = addr_q.pop_front();
         a = (a & 16'h07FF) | 16'(($urandom_range(0, 3)) << 11);
         cpu_read("rd_ram_rand", a);
      end
      for (int k = 0; k < 8; k++) cpu_read("rd_rom_rand", 16'h8000 | 16'($urandom));
      cpu_read("rd_open_5000", 16'h5000);
      cpu_read("rd_open_4014", 16'h4014);

      // PPU write/read
      cpu_write(16'h3FFE, 8'h77);
      chk("ppu_we", cap_ppu_we, 1'b1);
      chk("ppu_reg", cap_ppu_reg, 3'd6);
      chk("ppu_wdata", cap_ppu_wdata, 8'h77);
      chk("ppu_wr_no_ram", cap_ram_we, 1'b0);
      rb = ppu_rd_cnt;
      cpu_read("rd_2002", 16'h2002);
      chk("ppu_rd_pulses", ppu_rd_cnt - rb, 1);

      cpu_write(16'h8000, 8'h12);
      chk("rom_wr_ram_we", cap_ram_we, 1'b0);
      chk("rom_wr_ppu_we", cap_ppu_we, 1'b0);
      cpu_read("rd_8000", 16'h8000);

      // DMA from RAM page 2 with stray CPU writes during the transfer
      for (int i = 0; i < 256; i++) cpu_write({8'h02, i[7:0]}, i[7:0] ^ 8'hA5);
      cpu_write(16'h0000, 8'h3C);
      dma_start(8'h02);
      dma_wait(1'b1);
      chk("dma2_len", wr_q.size() - wb, 256);
      chk("dma2_halt", halt_cnt - hb, exp_halt());
      chk("dma2_ppu_rd", ppu_rd_cnt - rb, 0);
      dma_check(8'h02, 256);
      cpu_read("rd_0000_after", 16'h0000);
      cpu_read("rd_open_after", 16'h5000);

      // DMA from PPU page, then open-bus page
      dma_start(8'h21);
      dma_wait(1'b0);
      chk("dma21_ppu_rd", ppu_rd_cnt - rb, 256);
      chk("dma21_halt", halt_cnt - hb, exp_halt());
      dma_check(8'h21, 256);
      dma_start(8'h50);
      dma_wait(1'b0);
      chk("dma50_len", wr_q.size() - wb, 256);
      dma_check(8'h50, 256);
      chk("dma50_cpu_data", cpu_data, exp_cpu_data);

      // Reset in the middle of a ROM-sourced DMA
      dma_start(8'h85);
      for (int i = 0; i < 1000 && (wr_q.size() - wb) < 100; i++) step();
      chk("rst_reach_100", wr_q.size() - wb, 100);
      reset = 1'b1;
      step();
      chk("rst_mid_halt", cpu_halt, 1'b0);
      chk("rst_mid_cpu_data", cpu_data, 8'h00);
      reset = 1'b0;
      exp_cpu_data = 8'h00;
      #1 chk("rst_mid_ppu_we", ppu_we, 1'b0);
      repeat (20) step();
      chk("rst_no_more_wr", wr_q.size() - wb, 100);
      dma_check(8'h85, 100);

      // Fresh full DMA from page 0 after the abort
      for (int i = 0; i < 256; i++) cpu_write({8'h00, i[7:0]}, 8'($urandom));
      dma_start(8'h00);
      dma_wait(1'b0);
      chk("dma0_len", wr_q.size() - wb, 256);
      chk("dma0_halt", halt_cnt - hb, exp_halt());
      dma_check(8'h00, 256);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/nes_memctl.md
NES_MEMCTL -- requirements
Module: nes_memctl

Interface
REQ-001 Parameter PRG_AW, default 15, PRG ROM address width; 14 means a 16 KB image mirrored across $8000-$FFFF.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cpu_address  input  16  CPU bus address.
REQ-005 cpu_out  input  8  CPU write data.
REQ-006 cpu_rd / cpu_we  input  1 each  CPU read / write strobes.
REQ-007 cpu_data  output  8  registered read data to the CPU.
REQ-008 cpu_halt  output  1  stalls the CPU while OAM DMA owns the bus.
REQ-009 ram_address  output  11, ram_wdata  output  8, ram_we  output  1, ram_rdata  input  8  2 KB work RAM; synchronous read, 1-cycle latency.
REQ-010 rom_address  output  PRG_AW, rom_rdata  input  8  PRG ROM; synchronous read, 1-cycle latency.
REQ-011 ppu_reg  output  3, ppu_wdata  output  8, ppu_we  output  1, ppu_rd  output  1, ppu_rdata  input  8  PPU register port; ppu_rdata is valid the cycle after ppu_rd.

Function
REQ-012 Decode: $0000-$1FFF RAM, address[10:0], mirrored every 2 KB; $2000-$3FFF PPU, ppu_reg = address[2:0]; $4014 write triggers DMA; $8000-$FFFF ROM, address[PRG_AW-1:0]; everything else is open bus.
REQ-013 Read: cpu_data updates one cycle after cpu_rd with the selected source's data; open-bus reads return the previous cpu_data value.
REQ-014 Write: cpu_we to RAM or PPU asserts ram_we or ppu_we in the same cycle, passing cpu_out through combinationally; ROM and open-bus writes have no effect.
REQ-015 ppu_rd is a single-cycle pulse per cpu_rd cycle to the PPU range, because PPU reads have side effects.
REQ-016 FSM states: IDLE, DMA_WAIT, DMA_READ, DMA_WRITE.
REQ-017 In IDLE, a write to $4014 latches page = cpu_out and index = 0, and the next state is DMA_WAIT.
REQ-018 cpu_halt goes high the cycle after the $4014 write and stays high until the FSM returns to IDLE.
REQ-019 DMA_WAIT lasts one cycle, then the FSM goes to DMA_READ.
REQ-020 DMA_READ drives the source address {page, index} through the REQ-012 decode, then goes to DMA_WRITE.
REQ-021 DMA_WRITE drives ppu_we=1, ppu_reg=4, ppu_wdata = source read data.
REQ-022 From DMA_WRITE: if index = 255, go to IDLE; otherwise increment index and go to DMA_READ.
REQ-023 Without alignment, the DMA holds cpu_halt high for exactly 513 cycles.
REQ-024 During DMA, CPU strobes are ignored: no RAM/PPU writes, no ppu_rd, and cpu_data holds its value.
REQ-025 A $4014 write during DMA is ignored; the page is not reloaded.
REQ-026 DMA source page $20-$3F reads the PPU and issues ppu_rd; pages $40-$7F return open bus (last cpu_data).
REQ-027 The index is 8 bits; the wrap from 255 terminates the DMA and never reads page+1.

Reset
REQ-028 reset forces state IDLE, index 0, page 0, cpu_data $00, and cpu_halt, ram_we, ppu_we, ppu_rd all 0 on the next edge.
REQ-029 Reset mid-DMA aborts the transfer; cpu_halt is low the cycle after reset is sampled, and no further PPU writes occur.
REQ-030 The cycle-parity flop resets to 0 (even).

Configuration
REQ-031 Macro NES_DMA_ALIGN_EN, when defined: a free-running parity flop toggles every clock.
REQ-032 With NES_DMA_ALIGN_EN defined, a DMA whose DMA_WAIT cycle falls on an odd parity inserts one extra wait cycle, giving 514 halt cycles.
REQ-033 Without NES_DMA_ALIGN_EN, there is no parity logic and every DMA halts for exactly 513 cycles.

Verification
REQ-034 Write $5A to $0001, then read $0801, $1001, $1801 -> each returns $5A one cycle after cpu_rd.
REQ-035 Write $77 to $3FFE -> ppu_we=1, ppu_reg=6, ppu_wdata=$77; read $2002 -> exactly one ppu_rd pulse.
REQ-036 Fill RAM $0200-$02FF with i XOR $A5, then write $02 to $4014 -> 256 ppu_we pulses to reg 4 with data (i XOR $A5) in order; cpu_halt high for 513 cycles (514 on odd start with NES_DMA_ALIGN_EN).
REQ-037 Assert reset at DMA index 100 -> halt low on the next cycle, no further ppu_we; a fresh $4014 write then starts a full 256-byte DMA.
REQ-038 During DMA, CPU writes $4014 and writes $0000 -> page unchanged, RAM $0000 unchanged; read $5000 after DMA -> cpu_data equals the previous value.
